// File: rtl/sensor_conditioner.sv
// rtl/sensor_conditioner.sv - synchronises and debounces the vehicle switches, averages temperature samples
module sensor_conditioner #(
  parameter int DB_CYCLES = 500000,
  parameter int DB_W      = 20
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ing_raw_i,
  input  logic       pres_raw_i,
  input  logic [7:0] temp_raw_i,
  input  logic       temp_vld_i,
  output logic       ing_o,
  output logic       pres_o,
  output logic [4:0] temp_o,
  output logic       temp_rdy_o,
  output logic       temp_upd_o
);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic            ing_s1, ing_s2, pres_s1, pres_s2;
  logic [DB_W-1:0] ing_cnt, pres_cnt;

  // Sync stages reset to their output's reset level so no spurious edge follows reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ing_s1  <= 1'b1;
      ing_s2  <= 1'b1;
      pres_s1 <= 1'b0;
      pres_s2 <= 1'b0;
    end else begin
      ing_s1  <= ing_raw_i;
      ing_s2  <= ing_s1;
      pres_s1 <= pres_raw_i;
      pres_s2 <= pres_s1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ing_o   <= 1'b1;
      ing_cnt <= '0;
    end else if (ing_s2 == ing_o) begin
      ing_cnt <= '0;
    end else if (ing_cnt == DB_LAST) begin
      ing_o   <= ing_s2;
      ing_cnt <= '0;
    end else begin
      ing_cnt <= ing_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pres_o   <= 1'b0;
      pres_cnt <= '0;
    end else if (pres_s2 == pres_o) begin
      pres_cnt <= '0;
    end else if (pres_cnt == DB_LAST) begin
      pres_o   <= pres_s2;
      pres_cnt <= '0;
    end else begin
      pres_cnt <= pres_cnt + 1'b1;
    end
  end

  logic [7:0] win [4];
  logic [9:0] sum, sum_new;
  logic [2:0] fill, fill_new;
  logic [7:0] avg;
  logic [4:0] avg_clamped;

  // Running sum: add the newest sample, drop the one leaving the window.
  always_comb begin
    sum_new     = sum + {2'b00, temp_raw_i} - {2'b00, win[3]};
    fill_new    = (fill == 3'd4) ? 3'd4 : fill + 3'd1;
    avg         = sum_new[9:2];
    avg_clamped = (avg > 8'd31) ? 5'd31 : avg[4:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 4; i++) win[i] <= 8'd0;
      sum        <= '0;
      fill       <= '0;
      temp_o     <= '0;
      temp_rdy_o <= 1'b0;
      temp_upd_o <= 1'b0;
    end else begin
      temp_upd_o <= 1'b0;
      if (temp_vld_i) begin
        win[0] <= temp_raw_i;
        for (int i = 1; i < 4; i++) win[i] <= win[i-1];
        sum  <= sum_new;
        fill <= fill_new;
        if (fill_new == 3'd4) begin
          temp_o     <= avg_clamped;
          temp_upd_o <= 1'b1;
          temp_rdy_o <= 1'b1;
        end
      end
    end
  end

endmodule
